// File: rtl/eval_mc_pkg.sv
// Shared types and helpers for the multi-channel chess-eval control block.
package eval_mc_pkg;

    localparam int unsigned RESULT_W_DEFAULT = 15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } ch_state_e;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eval_mc_ctrl_if.sv
// Host register-side bus of eval_mc_ctrl: channel-addressed writes and read-back mux.
interface eval_mc_ctrl_if #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned MEM_DEPTH = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RESULT_W  = 15
);
    localparam int unsigned CH_W = eval_mc_pkg::ch_idx_w(NUM_CH);
    localparam int unsigned AW   = $clog2(MEM_DEPTH);

    logic [CH_W-1:0]     ch_sel_in;
    logic                reg_data_in;
    logic                start_wr_in;
    logic                side_wr_in;
    logic                mem_wr_in;
    logic [AW-1:0]       mem_wr_addr_in;
    logic [DATA_W-1:0]   mem_data_in;
    logic                start_axi_out;
    logic                side_axi_out;
    logic [RESULT_W-1:0] result_axi_out;
    logic                finished_axi_out;
    logic [31:0]         cycles_axi_out;

    modport master (
        output ch_sel_in, reg_data_in, start_wr_in, side_wr_in, mem_wr_in, mem_wr_addr_in,
               mem_data_in,
        input  start_axi_out, side_axi_out, result_axi_out, finished_axi_out, cycles_axi_out
    );

    modport slave (
        input  ch_sel_in, reg_data_in, start_wr_in, side_wr_in, mem_wr_in, mem_wr_addr_in,
               mem_data_in,
        output start_axi_out, side_axi_out, result_axi_out, finished_axi_out, cycles_axi_out
    );

endinterface

// File: rtl/eval_ch_ctrl.sv
// One eval channel: board staging, load mask, start/run/done FSM, result capture.
// Optional run-cycle counter enabled by defining EVAL_MC_CYCLE_CNT_EN.
module eval_ch_ctrl import eval_mc_pkg::*; #(
    parameter int unsigned MEM_DEPTH = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RESULT_W  = RESULT_W_DEFAULT,
    localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_wr_i,
    input  logic                          side_wr_i,
    input  logic                          mem_wr_i,
    input  logic                          reg_data_i,
    input  logic [AW-1:0]                 mem_wr_addr_i,
    input  logic [DATA_W-1:0]             mem_data_i,
    input  logic                          core_done_i,
    input  logic [RESULT_W-1:0]           core_result_i,
    output logic                          start_o,
    output logic                          side_o,
    output logic [RESULT_W-1:0]           result_o,
    output logic                          finished_o,
    output logic [31:0]                   cycles_o,
    output logic [MEM_DEPTH*DATA_W-1:0]   board_o,
    output logic                          core_start_o,
    output logic                          core_abort_o
);

    ch_state_e             state_q;
    logic                  start_q;
    logic                  side_q;
    logic [RESULT_W-1:0]   result_q;
    logic [MEM_DEPTH-1:0]  mask_q;
    logic [DATA_W-1:0]     board_q [MEM_DEPTH];
    logic                  core_start_q;
    logic                  core_abort_q;
    logic                  addr_ok;
    logic                  go;

    assign addr_ok = (32'(mem_wr_addr_i) < MEM_DEPTH);
    assign go      = (state_q == StIdle) && start_q && (&mask_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            start_q      <= 1'b0;
            side_q       <= 1'b0;
            result_q     <= '0;
            mask_q       <= '0;
            core_start_q <= 1'b0;
            core_abort_q <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                board_q[i] <= '0;
            end
        end else begin
            core_start_q <= 1'b0;
            core_abort_q <= 1'b0;
            if (start_wr_i) start_q <= reg_data_i;
            if (side_wr_i)  side_q  <= reg_data_i;
            // Board is frozen while the core may be reading it.
            if (mem_wr_i && addr_ok && (state_q == StIdle)) begin
                board_q[mem_wr_addr_i] <= mem_data_i;
                mask_q[mem_wr_addr_i]  <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        state_q      <= StRun;
                        core_start_q <= 1'b1;
                    end
                end
                StRun: begin
                    // A done in the same cycle as a start-clear takes priority over abort.
                    if (core_done_i) begin
                        state_q  <= StDone;
                        result_q <= core_result_i;
                    end else if (!start_q) begin
                        state_q      <= StIdle;
                        core_abort_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (!start_q) begin
                        state_q <= StIdle;
                        mask_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef EVAL_MC_CYCLE_CNT_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= '0;
        end else if (go) begin
            cycles_q <= '0;
        end else if ((state_q == StRun) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles_o = cycles_q;
`else
    assign cycles_o = '0;
`endif

    for (genvar w = 0; w < MEM_DEPTH; w++) begin : g_board
        assign board_o[w*DATA_W +: DATA_W] = board_q[w];
    end

    assign start_o      = start_q;
    assign side_o       = side_q;
    assign result_o     = result_q;
    assign finished_o   = (state_q == StDone);
    assign core_start_o = core_start_q;
    assign core_abort_o = core_abort_q;

endmodule

// File: rtl/eval_mc_ctrl.sv
// Host staging/control for NUM_CH chess-eval cores: write decode and read-back mux.
// Define EVAL_MC_CYCLE_CNT_EN to add per-channel run-cycle counters.
module eval_mc_ctrl import eval_mc_pkg::*; #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned MEM_DEPTH = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RESULT_W  = RESULT_W_DEFAULT
) (
    input  logic                                clk,
    input  logic                                rst,
    eval_mc_ctrl_if.slave                       host,
    output logic [NUM_CH*MEM_DEPTH*DATA_W-1:0]  core_board_out,
    output logic [NUM_CH-1:0]                   core_side_out,
    output logic [NUM_CH-1:0]                   core_start_out,
    output logic [NUM_CH-1:0]                   core_abort_out,
    input  logic [NUM_CH-1:0]                   core_done_in,
    input  logic [NUM_CH*RESULT_W-1:0]          core_result_in
);

    localparam int unsigned BOARD_W = MEM_DEPTH * DATA_W;

    logic [NUM_CH-1:0]   start_ch;
    logic [NUM_CH-1:0]   fin_ch;
    logic [RESULT_W-1:0] result_ch [NUM_CH];
    logic [31:0]         cycles_ch [NUM_CH];

    logic                start_rd;
    logic                side_rd;
    logic                fin_rd;
    logic [RESULT_W-1:0] result_rd;
    logic [31:0]         cycles_rd;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        assign sel = (32'(host.ch_sel_in) == 32'(c));

        eval_ch_ctrl #(
            .MEM_DEPTH (MEM_DEPTH),
            .DATA_W    (DATA_W),
            .RESULT_W  (RESULT_W)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .start_wr_i    (sel & host.start_wr_in),
            .side_wr_i     (sel & host.side_wr_in),
            .mem_wr_i      (sel & host.mem_wr_in),
            .reg_data_i    (host.reg_data_in),
            .mem_wr_addr_i (host.mem_wr_addr_in),
            .mem_data_i    (host.mem_data_in),
            .core_done_i   (core_done_in[c]),
            .core_result_i (core_result_in[c*RESULT_W +: RESULT_W]),
            .start_o       (start_ch[c]),
            .side_o        (core_side_out[c]),
            .result_o      (result_ch[c]),
            .finished_o    (fin_ch[c]),
            .cycles_o      (cycles_ch[c]),
            .board_o       (core_board_out[c*BOARD_W +: BOARD_W]),
            .core_start_o  (core_start_out[c]),
            .core_abort_o  (core_abort_out[c])
        );
    end

    // Out-of-range selects match no channel and read back as zero.
    always_comb begin
        start_rd  = 1'b0;
        side_rd   = 1'b0;
        fin_rd    = 1'b0;
        result_rd = '0;
        cycles_rd = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(host.ch_sel_in) == 32'(c)) begin
                start_rd  = start_ch[c];
                side_rd   = core_side_out[c];
                fin_rd    = fin_ch[c];
                result_rd = result_ch[c];
                cycles_rd = cycles_ch[c];
            end
        end
    end

    assign host.start_axi_out    = start_rd;
    assign host.side_axi_out     = side_rd;
    assign host.finished_axi_out = fin_rd;
    assign host.result_axi_out   = result_rd;
    assign host.cycles_axi_out   = cycles_rd;

endmodule

// File: tb/tb_eval_mc_ctrl.sv
// Directed self-checking bench for eval_mc_ctrl (main NUM_CH=2 instance, NUM_CH=3 for select range).
module tb_eval_mc_ctrl;

`ifdef EVAL_MC_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    eval_mc_ctrl_if #(.NUM_CH(2), .MEM_DEPTH(8), .DATA_W(32), .RESULT_W(15)) h ();
    eval_mc_ctrl_if #(.NUM_CH(3), .MEM_DEPTH(8), .DATA_W(32), .RESULT_W(15)) hb ();

    logic [511:0] core_board;
    logic [1:0]   core_side;
    logic [1:0]   core_start;
    logic [1:0]   core_abort;
    logic [1:0]   core_done;
    logic [29:0]  core_result;

    logic [767:0] b_board;
    logic [2:0]   b_side;
    logic [2:0]   b_start;
    logic [2:0]   b_abort;
    logic [2:0]   b_done;
    logic [44:0]  b_result;

    int errors = 0;
    int checks = 0;

    eval_mc_ctrl #(.NUM_CH(2), .MEM_DEPTH(8), .DATA_W(32), .RESULT_W(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .host           (h),
        .core_board_out (core_board),
        .core_side_out  (core_side),
        .core_start_out (core_start),
        .core_abort_out (core_abort),
        .core_done_in   (core_done),
        .core_result_in (core_result)
    );

    eval_mc_ctrl #(.NUM_CH(3), .MEM_DEPTH(8), .DATA_W(32), .RESULT_W(15)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .host           (hb),
        .core_board_out (b_board),
        .core_side_out  (b_side),
        .core_start_out (b_start),
        .core_abort_out (b_abort),
        .core_done_in   (b_done),
        .core_result_in (b_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd(input int ch);
        h.ch_sel_in = 1'(ch);
        #1;
    endtask

    task automatic wr_mem(input int ch, input int addr, input logic [31:0] d);
        h.ch_sel_in      = 1'(ch);
        h.mem_wr_addr_in = 3'(addr);
        h.mem_data_in    = d;
        h.mem_wr_in      = 1'b1;
        tick();
        h.mem_wr_in      = 1'b0;
    endtask

    task automatic wr_start(input int ch, input logic v);
        h.ch_sel_in   = 1'(ch);
        h.reg_data_in = v;
        h.start_wr_in = 1'b1;
        tick();
        h.start_wr_in = 1'b0;
    endtask

    task automatic wr_side(input int ch, input logic v);
        h.ch_sel_in   = 1'(ch);
        h.reg_data_in = v;
        h.side_wr_in  = 1'b1;
        tick();
        h.side_wr_in  = 1'b0;
    endtask

    function automatic logic [31:0] bword(input int ch, input int w);
        return core_board[(ch*8+w)*32 +: 32];
    endfunction

    initial begin
        rst = 1'b1;
        h.ch_sel_in = '0; h.reg_data_in = 0; h.start_wr_in = 0; h.side_wr_in = 0;
        h.mem_wr_in = 0; h.mem_wr_addr_in = '0; h.mem_data_in = '0;
        hb.ch_sel_in = '0; hb.reg_data_in = 0; hb.start_wr_in = 0; hb.side_wr_in = 0;
        hb.mem_wr_in = 0; hb.mem_wr_addr_in = '0; hb.mem_data_in = '0;
        core_done = '0; core_result = '0; b_done = '0; b_result = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        for (int c = 0; c < 2; c++) begin
            rd(c);
            check("rst_start", 32'(h.start_axi_out), 0);
            check("rst_side", 32'(h.side_axi_out), 0);
            check("rst_result", 32'(h.result_axi_out), 0);
            check("rst_finished", 32'(h.finished_axi_out), 0);
            check("rst_cycles", h.cycles_axi_out, 0);
        end
        check("rst_board_nonzero", 32'(core_board != '0), 0);
        check("rst_pulses_side", 32'({core_start, core_abort, core_side}), 0);

        // ch1 full load, start, done after 5 run cycles
        for (int w = 0; w < 8; w++) wr_mem(1, w, 32'h1111_1111 * (w + 1));
        check("t2_board_w0", bword(1, 0), 32'h1111_1111);
        check("t2_board_w7", bword(1, 7), 32'h8888_8888);
        check("t2_board_ch0", bword(0, 0), 32'h0);
        wr_start(1, 1'b1);
        check("t2_no_early_pulse", 32'(core_start), 0);
        tick();
        check("t2_start_pulse", 32'(core_start), 32'h2);
        rd(1);
        check("t2_start_reg", 32'(h.start_axi_out), 1);
        tick();
        check("t2_pulse_one_cycle", 32'(core_start), 0);
        repeat (3) tick();
        core_done   = 2'b10;
        core_result = {15'h7F00, 15'h0};
        tick();
        core_done   = 2'b00;
        rd(1);
        check("t2_finished", 32'(h.finished_axi_out), 1);
        check("t2_result", 32'(h.result_axi_out), 32'h7F00);
        check("t2_cycles", h.cycles_axi_out, CNT_EN ? 32'd5 : 32'd0);
        tick();
        check("t2_cycles_frozen", h.cycles_axi_out, CNT_EN ? 32'd5 : 32'd0);
        check("t2_still_done", 32'(h.finished_axi_out), 1);

        // ch0 start with incomplete mask; stray done in IDLE
        for (int w = 0; w < 7; w++) wr_mem(0, w, 32'hA000_0000 + 32'(w));
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        rd(0);
        check("t3_done_idle_ignored", 32'(h.finished_axi_out), 0);
        wr_start(0, 1'b1);
        repeat (3) tick();
        check("t3_no_pulse_partial", 32'(core_start), 0);
        wr_mem(0, 7, 32'hA000_0007);
        check("t3_no_pulse_yet", 32'(core_start), 0);
        tick();
        check("t3_pulse_after_last", 32'(core_start), 32'h1);

        // ch0 side write in RUN, abort, restart without reload
        wr_side(0, 1'b1);
        check("t4_core_side", 32'(core_side), 32'h1);
        wr_start(0, 1'b0);
        check("t4_no_abort_yet", 32'(core_abort), 0);
        tick();
        check("t4_abort_pulse", 32'(core_abort), 32'h1);
        rd(0);
        check("t4_not_finished", 32'(h.finished_axi_out), 0);
        tick();
        check("t4_abort_one_cycle", 32'(core_abort), 0);
        wr_start(0, 1'b1);
        tick();
        check("t4_restart_pulse", 32'(core_start), 32'h1);
        rd(0);
        check("t4_cycles_cleared", h.cycles_axi_out, 0);

        // ch0 DONE: dropped mem write, then release clears mask
        core_done   = 2'b01;
        core_result = {15'h0, 15'h0123};
        tick();
        core_done   = 2'b00;
        rd(0);
        check("t5_finished", 32'(h.finished_axi_out), 1);
        check("t5_result", 32'(h.result_axi_out), 32'h0123);
        check("t5_cycles", h.cycles_axi_out, CNT_EN ? 32'd1 : 32'd0);
        wr_mem(0, 3, 32'hDEAD_BEEF);
        check("t5_write_dropped", bword(0, 3), 32'hA000_0003);
        wr_start(0, 1'b0);
        tick();
        rd(0);
        check("t5_finished_clear", 32'(h.finished_axi_out), 0);
        check("t5_result_held", 32'(h.result_axi_out), 32'h0123);
        check("t5_no_abort", 32'(core_abort), 0);
        wr_start(0, 1'b1);
        tick();
        check("t5_mask_cleared", 32'(core_start), 0);
        wr_mem(0, 3, 32'hDEAD_BEEF);
        check("t5_write_idle", bword(0, 3), 32'hDEAD_BEEF);
        wr_start(0, 1'b0);

        // ch1: done and start-clear seen together
        wr_start(1, 1'b0);
        tick();
        rd(1);
        check("t6_release", 32'(h.finished_axi_out), 0);
        for (int w = 0; w < 8; w++) wr_mem(1, w, 32'hB000_0000 + 32'(w));
        wr_start(1, 1'b1);
        tick();
        check("t6_start_pulse", 32'(core_start), 32'h2);
        h.ch_sel_in   = 1'b1;
        h.reg_data_in = 1'b0;
        h.start_wr_in = 1'b1;
        tick();
        h.start_wr_in = 1'b0;
        core_done     = 2'b10;
        core_result   = {15'h4001, 15'h0};
        tick();
        core_done     = 2'b00;
        check("t6_no_abort", 32'(core_abort), 0);
        rd(1);
        check("t6_finished", 32'(h.finished_axi_out), 1);
        check("t6_result", 32'(h.result_axi_out), 32'h4001);
        tick();
        check("t6_no_abort_after", 32'(core_abort), 0);
        check("t6_back_idle", 32'(h.finished_axi_out), 0);

        // Out-of-range channel select on a 3-channel instance
        hb.ch_sel_in   = 2'd2;
        hb.reg_data_in = 1'b1;
        hb.start_wr_in = 1'b1;
        hb.side_wr_in  = 1'b1;
        tick();
        hb.start_wr_in = 1'b0;
        hb.side_wr_in  = 1'b0;
        #1;
        check("b_ch2_start", 32'(hb.start_axi_out), 1);
        check("b_ch2_side", 32'(b_side), 32'h4);
        hb.ch_sel_in = 2'd3;
        #1;
        check("b_sel3_start", 32'(hb.start_axi_out), 0);
        check("b_sel3_side", 32'(hb.side_axi_out), 0);
        check("b_sel3_result", 32'(hb.result_axi_out), 0);
        check("b_sel3_finished", 32'(hb.finished_axi_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
